// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Pipelined unsigned WxW multiplier. Each transaction selects one of two
//   modes. Exact mode returns the full 2W-bit product. Approximate mode drops
//   the low L product columns. It replaces them with a single compensation
//   bit, which is the OR of columns L-1 and L-2, weighted 2^(L-1).
//   All stages advance together on one global enable. That enable is also
//   in_ready, so a stalled output freezes the whole pipe and bubbles travel
//   as valid=0.
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      upstream handshake; x, y, in_approx taken on transfer
//   out_valid/out_ready    downstream handshake; z, out_approx held while stalled
//   txn_cnt                number of delivered results, wraps at 2^CNTW
module approx_mult_pipe #(
    parameter int W      = 8,
    parameter int L      = 8,
    parameter int STAGES = 2,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_approx,
    input  logic [W-1:0]    x,
    input  logic [W-1:0]    y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  z,
    output logic            out_approx,
    output logic [CNTW-1:0] txn_cnt
);

    // Weight of the compensation bit. It is clamped so that L=0 never shifts
    // by a negative amount. With L=0 the bit is never added.
    localparam int CSH = (L > 0) ? (L - 1) : 0;

    // Partial-product accumulation. Columns below L are excluded in approx
    // mode. Columns L-1 and L-2 feed the OR compensation bit instead.
    function automatic logic [2*W-1:0] f_mult(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic         apx);
        logic [2*W-1:0] acc;
        logic           comp;
        logic           pp;
        acc  = '0;
        comp = 1'b0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp = a[i] & b[j];
                if (!apx || ((i + j) >= L)) begin
                    acc = acc + ({{(2*W-1){1'b0}}, pp} << (i + j));
                end else if (((i + j) == (L - 1)) || ((i + j) == (L - 2))) begin
                    comp = comp | pp;
                end else begin
                    comp = comp;
                end
            end
        end
        if (apx && (L > 0)) begin
            acc = acc + ({{(2*W-1){1'b0}}, comp} << CSH);
        end else begin
            acc = acc;
        end
        return acc;
    endfunction

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_apx;
    logic [2*W-1:0]    r_z [STAGES];
    logic              r_live;
    logic [CNTW-1:0]   r_cnt;

    logic              w_en;
    logic              w_take;
    logic              w_deliver;
    logic [2*W-1:0]    w_prod;

    // The pipe advances whenever the output slot is empty or being drained.
    // in_ready stays low until the first clock edge after reset.
    assign w_en      = ~r_vld[STAGES-1] | out_ready;
    assign in_ready  = r_live & w_en;
    assign w_take    = in_valid & in_ready;
    assign w_deliver = r_vld[STAGES-1] & out_ready;
    assign w_prod    = f_mult(x, y, in_approx);

    // Pipeline stages: the product is captured in stage 1, then shifted
    // towards the output, with its valid bit and mode bit alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_vld  <= '0;
            r_apx  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_z[s] <= '0;
            end
        end else begin
            r_live <= 1'b1;
            if (w_en) begin
                r_vld[0] <= w_take;
                r_apx[0] <= in_approx;
                r_z[0]   <= w_prod;
                for (int s = 1; s < STAGES; s++) begin
                    r_vld[s] <= r_vld[s-1];
                    r_apx[s] <= r_apx[s-1];
                    r_z[s]   <= r_z[s-1];
                end
            end
        end
    end

    // Delivered-transaction counter; wraps naturally at 2^CNTW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_deliver) begin
            r_cnt <= r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid  = r_vld[STAGES-1];
    assign out_approx = r_apx[STAGES-1];
    assign z          = r_z[STAGES-1];
    assign txn_cnt    = r_cnt;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe
//   Scoreboard bench for approx_mult_pipe. Instance 0 uses W=8, L=8,
//   STAGES=2. It runs the directed, stall, reset and streaming tests.
//   Three more instances cover the other parameter points:
//     L=0, STAGES=1
//     L=1, STAGES=4, CNTW=4
//     W=4, L=4, STAGES=3
//   Their outputs are always ready.
//   When an input transfer is seen, its expected result is queued. The
//   monitor pops that entry when the result is delivered.
module tb_approx_mult_pipe;

    typedef struct {
        logic [31:0] z;
        logic        m;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // instance 0 (W=8, L=8, STAGES=2)
    logic        in_valid, in_ready, in_approx, out_valid, out_ready, out_approx;
    logic [7:0]  x, y;
    logic [15:0] z, txn_cnt, pend_z;
    // shared sweep stimulus
    logic        s_valid, s_apx, s_ordy;
    logic [7:0]  s_x, s_y;
    logic        rdy_b, ov_b, oa_b, rdy_c, ov_c, oa_c, rdy_d, ov_d, oa_d;
    logic [15:0] z_b, z_c, cnt_b;
    logic [7:0]  z_d, cnt_d;
    logic [3:0]  cnt_c;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   dlv [4];
    exp_t qs [4][$];
    logic main_lat;

    approx_mult_pipe #(.W(8), .L(8), .STAGES(2), .CNTW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_approx(in_approx), .x(x), .y(y), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .out_approx(out_approx), .txn_cnt(txn_cnt));

    approx_mult_pipe #(.W(8), .L(0), .STAGES(1), .CNTW(16)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(rdy_b),
        .in_approx(s_apx), .x(s_x), .y(s_y), .out_valid(ov_b),
        .out_ready(s_ordy), .z(z_b), .out_approx(oa_b), .txn_cnt(cnt_b));

    approx_mult_pipe #(.W(8), .L(1), .STAGES(4), .CNTW(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(rdy_c),
        .in_approx(s_apx), .x(s_x), .y(s_y), .out_valid(ov_c),
        .out_ready(s_ordy), .z(z_c), .out_approx(oa_c), .txn_cnt(cnt_c));

    approx_mult_pipe #(.W(4), .L(4), .STAGES(3), .CNTW(8)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(rdy_d),
        .in_approx(s_apx), .x(s_x[3:0]), .y(s_y[3:0]), .out_valid(ov_d),
        .out_ready(s_ordy), .z(z_d), .out_approx(oa_d), .txn_cnt(cnt_d));

    // Reference product. This is a row-wise formulation. For row i, only the
    // multiplier bits j with i+j >= l are kept. The compensation bit reads
    // the multiplier bits that land in columns l-1 and l-2.
    function automatic logic [31:0] ref_mult(input int w, input int l,
                                             input logic [15:0] a, input logic [15:0] b,
                                             input logic m);
        logic [31:0] h, row;
        logic        c;
        int          sh;
        if (!m || l == 0) return {16'd0, a} * {16'd0, b};
        h = 32'd0;
        c = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (a[i]) begin
                sh  = (l - i > 0) ? (l - i) : 0;
                row = ({16'd0, b} >> sh) << sh;
                h   = h + (row << i);
                if (l - 1 - i >= 0 && l - 1 - i < w) c = c | b[l-1-i];
                if (l - 2 - i >= 0 && l - 2 - i < w) c = c | b[l-2-i];
            end
        end
        return h + ({31'd0, c} << (l - 1));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic mon(input int k, input string nm, input logic acc, input logic m,
                       input logic [31:0] ez, input logic dv, input logic [31:0] az,
                       input logic am, input int lat, input logic lchk);
        exp_t e;
        if (acc) begin
            e.z = ez; e.m = m; e.cyc = cyc;
            qs[k].push_back(e);
        end
        if (dv) begin
            if (qs[k].size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s_spurious: got result %0d required no output", nm, az);
            end else begin
                e = qs[k].pop_front();
                chk({nm, "_z"}, {32'd0, az}, {32'd0, e.z});
                chk({nm, "_mode"}, {63'd0, am}, {63'd0, e.m});
                if (lchk) chk({nm, "_latency"}, 64'(cyc - e.cyc), 64'(lat));
            end
            dlv[k]++;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard push and pop for every instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("c_txn_cnt", {60'd0, cnt_c}, {60'd0, dlv[2][3:0]});
            mon(0, "main", in_valid && in_ready, in_approx, {16'd0, pend_z},
                out_valid && out_ready, {16'd0, z}, out_approx, 2, main_lat);
            mon(1, "b_L0S1", s_valid && rdy_b, s_apx,
                ref_mult(8, 0, {8'd0, s_x}, {8'd0, s_y}, s_apx),
                ov_b, {16'd0, z_b}, oa_b, 1, 1'b1);
            mon(2, "c_L1S4", s_valid && rdy_c, s_apx,
                ref_mult(8, 1, {8'd0, s_x}, {8'd0, s_y}, s_apx),
                ov_c, {16'd0, z_c}, oa_c, 4, 1'b1);
            mon(3, "d_W4L4S3", s_valid && rdy_d, s_apx,
                ref_mult(4, 4, {12'd0, s_x[3:0]}, {12'd0, s_y[3:0]}, s_apx),
                ov_d, {24'd0, z_d}, oa_d, 3, 1'b1);
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input logic [15:0] e);
        int n;
        x = a; y = b; in_approx = m; pend_z = e; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 required 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        int left;
        n = 0;
        left = qs[0].size() + qs[1].size() + qs[2].size() + qs[3].size();
        while (left != 0 && n < 60) begin
            @(negedge clk);
            n++;
            left = qs[0].size() + qs[1].size() + qs[2].size() + qs[3].size();
        end
        chk("drain_left", 64'(left), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_approx = 1'b0; x = 8'd0; y = 8'd0;
        out_ready = 1'b1; pend_z = 16'd0; main_lat = 1'b1;
        s_valid = 1'b0; s_apx = 1'b0; s_x = 8'd0; s_y = 8'd0; s_ordy = 1'b1;
        for (int k = 0; k < 4; k++) dlv[k] = 0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_z", {48'd0, z}, 64'd0);
        chk("rst_txn_cnt", {48'd0, txn_cnt}, 64'd0);
        #21;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Directed products with hand-computed results.
        send(8'd255, 8'd255, 1'b0, 16'd65025);
        send(8'd255, 8'd255, 1'b1, 16'd63360);
        send(8'd3,   8'd5,   1'b1, 16'd0);
        send(8'd64,  8'd1,   1'b1, 16'd128);
        send(8'd128, 8'd1,   1'b1, 16'd128);
        send(8'd200, 8'd100, 1'b0, 16'd20000);
        send(8'd15,  8'd15,  1'b1, 16'd128);
        drain();

        // Backpressure: fill the pipe, hold out_ready low for 5 cycles.
        main_lat  = 1'b0;
        out_ready = 1'b0;
        send(8'd10, 8'd20, 1'b0, 16'd200);
        send(8'd15, 8'd15, 1'b1, 16'd128);
        x = 8'd7; y = 8'd9; in_approx = 1'b0; pend_z = 16'd63; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_z", {48'd0, z}, 64'd200);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        main_lat = 1'b1;

        // Async reset with two transactions in flight.
        send(8'd20, 8'd30, 1'b0, 16'd600);
        send(8'd40, 8'd50, 1'b0, 16'd2000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_txn_cnt", {48'd0, txn_cnt}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            qs[k].delete();
            dlv[k] = 0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_output", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // 100 back-to-back random transactions, out_ready held high.
        for (int i = 0; i < 100; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            in_approx = 1'($urandom_range(0, 1));
            pend_z = 16'(ref_mult(8, 8, {8'd0, x}, {8'd0, y}, in_approx));
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("stream_txn_cnt", {48'd0, txn_cnt}, 64'd100);

        // Parameter sweep instances: 5 directed then 40 random transactions.
        s_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            case (i)
                0:       begin s_x = 8'd15;  s_y = 8'd15;  s_apx = 1'b1; end
                1:       begin s_x = 8'd1;   s_y = 8'd1;   s_apx = 1'b1; end
                2:       begin s_x = 8'd255; s_y = 8'd255; s_apx = 1'b1; end
                3:       begin s_x = 8'd64;  s_y = 8'd1;   s_apx = 1'b1; end
                4:       begin s_x = 8'd3;   s_y = 8'd5;   s_apx = 1'b0; end
                default: begin
                    s_x = 8'($urandom_range(0, 255));
                    s_y = 8'($urandom_range(0, 255));
                    s_apx = 1'($urandom_range(0, 1));
                end
            endcase
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        drain();
        chk("b_txn_cnt", {48'd0, cnt_b}, 64'd45);
        chk("c_txn_cnt_wrapped", {60'd0, cnt_c}, 64'd13);
        chk("d_txn_cnt", {56'd0, cnt_d}, 64'd45);
        chk("main_txn_cnt_idle", {48'd0, txn_cnt}, 64'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
